// File: rtl/d_alu_pkg.sv
// Shared definitions for the D-ALU conversion path: rounding-mode encodings,
// fflags layout, binary64 field geometry, int32 saturation values and the
// converter state machine encoding.
package d_alu_pkg;

  // Resolved RISC-V rounding modes (DYN never reaches the converters)
  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  // fflags = {NV,DZ,OF,UF,NX}
  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;
  localparam logic [4:0] FFLAGS_NV = 5'(1) << FFLAG_NV;
  localparam logic [4:0] FFLAGS_NX = 5'(1) << FFLAG_NX;

  // binary64 geometry
  localparam int DP_BIAS   = 1023;
  localparam int DP_EXP_W  = 11;
  localparam int DP_FRAC_W = 52;

  // 32-bit saturation results
  localparam logic [31:0] INT32_POS_SAT  = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_NEG_SAT  = 32'h8000_0000;
  localparam logic [31:0] UINT32_POS_SAT = 32'hFFFF_FFFF;
  localparam logic [31:0] UINT32_NEG_SAT = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_SHIFT,
    ST_ROUND,
    ST_DONE
  } cvtState_e;

  // Saturation value for the requested signedness and the operand direction
  function automatic logic [31:0] satValue(input logic signedCtrl, input logic neg);
    if (signedCtrl) return neg ? INT32_NEG_SAT : INT32_POS_SAT;
    else            return neg ? UINT32_NEG_SAT : UINT32_POS_SAT;
  endfunction

endpackage

// File: rtl/fp_round_decide.sv
// Rounding decision shared by the D-ALU converters: from the rounding mode,
// sign, result lsb, guard and sticky bits decide whether to bump the
// magnitude and whether the result is inexact.
module fp_round_decide
  import d_alu_pkg::*;
(
  input  logic [2:0] rm_i,
  input  logic       sgn_i,
  input  logic       lsb_i,
  input  logic       guard_i,
  input  logic       sticky_i,
  output logic       incr_o,
  output logic       inexact_o
);

  // Increment decision per rounding mode; reserved encodings truncate
  always_comb begin
    inexact_o = guard_i | sticky_i;
    incr_o    = 1'b0;
    case (rm_i)
      RM_RNE:  incr_o = guard_i & (sticky_i | lsb_i);
      RM_RTZ:  incr_o = 1'b0;
      RM_RDN:  incr_o = inexact_o & sgn_i;
      RM_RUP:  incr_o = inexact_o & ~sgn_i;
      RM_RMM:  incr_o = guard_i;
      default: incr_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_cvt_dw.sv
// FCVT.W.D / FCVT.WU.D: multi-cycle binary64 -> 32-bit integer conversion.
// The significand is aligned by an iterative right shifter (SHIFT_STEP bits
// per cycle) that collects guard/sticky, then rounded, range checked and
// saturated. Valid/ready handshakes on both sides.
module fp_cvt_dw
  import d_alu_pkg::*;
#(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] d,
  input  logic        signed_ctrl,
  input  logic [2:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] w,
  output logic [4:0]  fflags
);

  localparam int               ACC_W   = DP_FRAC_W + 1;
  localparam logic [ACC_W-1:0] ACC_ONE = ACC_W'(1);
  localparam logic [5:0]       STEP6   = 6'(SHIFT_STEP);
  localparam logic [3:0]       STEP4   = 4'(SHIFT_STEP);

  cvtState_e         state_q, state_d;
  logic [63:0]       opnd_q, opnd_d;
  logic              signedCtrl_q, signedCtrl_d;
  logic [2:0]        rm_q, rm_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              guard_q, guard_d;
  logic              sticky_q, sticky_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [31:0]       w_q, w_d;
  logic [4:0]        fflags_q, fflags_d;

  logic                sgn;
  logic                isZero, isSpecialExp, isNaN;
  logic signed [12:0]  unbExp, cntFull;
  logic [5:0]          cntInit;
  logic [ACC_W-1:0]    sig, shiftedM1, lowMask;
  logic [3:0]          shiftAmt;
  logic [32:0]         mag;
  logic                roundIncr, roundInexact, overRange;

  // Operand field decode
  assign sgn          = opnd_q[63];
  assign isZero       = (opnd_q[62:0] == 63'd0);
  assign isSpecialExp = &opnd_q[62:52];
  assign isNaN        = isSpecialExp & (|opnd_q[51:0]);
  assign unbExp       = $signed({2'b00, opnd_q[62:52]}) - 13'(DP_BIAS);
  assign sig          = {|opnd_q[62:52], opnd_q[51:0]};
  assign cntFull      = 13'sd52 - unbExp;
  assign cntInit      = (cntFull > 13'sd54) ? 6'd54 : cntFull[5:0];

  // One shifter step: the bit just below the new lsb becomes guard, the rest sticky
  assign shiftAmt  = (cnt_q < STEP6) ? cnt_q[3:0] : STEP4;
  assign shiftedM1 = acc_q >> (shiftAmt - 4'd1);
  assign lowMask   = (ACC_ONE << (shiftAmt - 4'd1)) - ACC_ONE;

  // Rounded magnitude and range check
  assign mag = {1'b0, acc_q[31:0]} + {32'd0, roundIncr};
  assign overRange = signedCtrl_q ? (sgn ? (mag > 33'h0_8000_0000) : (mag > 33'h0_7FFF_FFFF))
                                  : (sgn ? (mag != 33'd0)          : (mag > 33'h0_FFFF_FFFF));

  fp_round_decide uRound (
    .rm_i      (rm_q),
    .sgn_i     (sgn),
    .lsb_i     (acc_q[0]),
    .guard_i   (guard_q),
    .sticky_i  (sticky_q),
    .incr_o    (roundIncr),
    .inexact_o (roundInexact)
  );

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      opnd_q       <= '0;
      signedCtrl_q <= 1'b0;
      rm_q         <= RM_RNE;
      acc_q        <= '0;
      guard_q      <= 1'b0;
      sticky_q     <= 1'b0;
      cnt_q        <= '0;
      w_q          <= '0;
      fflags_q     <= '0;
    end else begin
      state_q      <= state_d;
      opnd_q       <= opnd_d;
      signedCtrl_q <= signedCtrl_d;
      rm_q         <= rm_d;
      acc_q        <= acc_d;
      guard_q      <= guard_d;
      sticky_q     <= sticky_d;
      cnt_q        <= cnt_d;
      w_q          <= w_d;
      fflags_q     <= fflags_d;
    end
  end

  // Next-state and datapath update for each conversion phase
  always_comb begin
    state_d      = state_q;
    opnd_d       = opnd_q;
    signedCtrl_d = signedCtrl_q;
    rm_d         = rm_q;
    acc_d        = acc_q;
    guard_d      = guard_q;
    sticky_d     = sticky_q;
    cnt_d        = cnt_q;
    w_d          = w_q;
    fflags_d     = fflags_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          opnd_d       = d;
          signedCtrl_d = signed_ctrl;
          rm_d         = rm;
          state_d      = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (isZero) begin
          w_d      = '0;
          fflags_d = '0;
          state_d  = ST_DONE;
        end else if (isSpecialExp) begin
          w_d      = satValue(signedCtrl_q, sgn & ~isNaN);
          fflags_d = FFLAGS_NV;
          state_d  = ST_DONE;
        end else if (unbExp > 13'sd31) begin
          w_d      = satValue(signedCtrl_q, sgn);
          fflags_d = FFLAGS_NV;
          state_d  = ST_DONE;
        end else begin
          acc_d    = sig;
          guard_d  = 1'b0;
          sticky_d = 1'b0;
          cnt_d    = cntInit;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sticky_d = sticky_q | guard_q | (|(acc_q & lowMask));
        guard_d  = shiftedM1[0];
        acc_d    = shiftedM1 >> 1;
        cnt_d    = cnt_q - {2'b00, shiftAmt};
        if (cnt_q == {2'b00, shiftAmt}) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        if (overRange) begin
          w_d      = satValue(signedCtrl_q, sgn);
          fflags_d = FFLAGS_NV;
        end else begin
          w_d      = sgn ? (32'd0 - mag[31:0]) : mag[31:0];
          fflags_d = roundInexact ? FFLAGS_NX : 5'd0;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign w         = w_q;
  assign fflags    = fflags_q;

endmodule

// File: tb/tb_fp_cvt_dw.sv
// Self-checking bench for fp_cvt_dw: directed corner cases plus random
// operands compared against a real-arithmetic reference model, including
// latency, backpressure, mid-operation reset and back-to-back operands.
module tb_fp_cvt_dw;

  localparam int STEP = 4;
  localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, signed_ctrl, out_valid, out_ready;
  logic [63:0] d;
  logic [2:0]  rm;
  logic [31:0] w;
  logic [4:0]  fflags;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  fp_cvt_dw #(.SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .d(d),
    .signed_ctrl(signed_ctrl), .rm(rm), .out_valid(out_valid),
    .out_ready(out_ready), .w(w), .fflags(fflags)
  );

  // Counts every comparison and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: exact real arithmetic on the operand value
  function automatic void refModel(input logic [63:0] dv, input logic sc, input logic [2:0] rmv,
                                   output logic [31:0] wExp, output logic [4:0] fExp, output int latExp);
    logic        neg, inex, up;
    int          e, cnt;
    real         a, fl, fr;
    longint      fli, m, r, limit;
    logic [31:0] satPos, satNeg;
    neg    = dv[63];
    e      = int'(dv[62:52]) - 1023;
    satPos = sc ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
    satNeg = sc ? 32'h8000_0000 : 32'h0000_0000;
    wExp   = 32'd0;
    fExp   = 5'd0;
    latExp = 2;
    if (dv[62:52] == 11'h7FF) begin
      fExp = 5'b10000;
      wExp = (dv[51:0] != 52'd0) ? satPos : (neg ? satNeg : satPos);
      return;
    end
    a = $bitstoreal(dv);
    if (a < 0.0) a = -a;
    if (a == 0.0) return;
    if (e <= 31) begin
      cnt = 52 - e;
      if (cnt > 54) cnt = 54;
      latExp = 3 + (cnt + STEP - 1) / STEP;
    end
    if (a >= 4294967296.0) begin
      fExp = 5'b10000;
      wExp = neg ? satNeg : satPos;
      return;
    end
    fl   = $floor(a);
    fr   = a - fl;
    fli  = longint'(fl);
    inex = (fr != 0.0);
    case (rmv)
      RNE:     up = (fr > 0.5) || (fr == 0.5 && fli[0]);
      RDN:     up = inex && neg;
      RUP:     up = inex && !neg;
      RMM:     up = (fr >= 0.5);
      default: up = 1'b0;
    endcase
    m = fli + (up ? 64'sd1 : 64'sd0);
    if (sc) begin
      limit = neg ? 64'sd2147483648 : 64'sd2147483647;
      if (m > limit) begin
        fExp = 5'b10000;
        wExp = neg ? satNeg : satPos;
        return;
      end
    end else begin
      if ((neg && m != 0) || (!neg && m > 64'sd4294967295)) begin
        fExp = 5'b10000;
        wExp = neg ? satNeg : satPos;
        return;
      end
    end
    r    = neg ? -m : m;
    wExp = r[31:0];
    fExp = inex ? 5'b00001 : 5'b00000;
  endfunction

  // Waits for out_valid within a cycle budget; cycles counts edges from acceptance
  task automatic waitResult(inout int cycles);
    while (out_valid !== 1'b1 && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  // One full transaction: accept, wait, check, optional backpressure, handshake
  task automatic applyStimulus(input logic [63:0] dv, input logic sc, input logic [2:0] rmv, input int holdCycles);
    logic [31:0] wExp;
    logic [4:0]  fExp;
    int          latExp, cycles;
    refModel(dv, sc, rmv, wExp, fExp, latExp);
    checkOutput("inReadyIdle", 64'(in_ready), 64'd1);
    d = dv; signed_ctrl = sc; rm = rmv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cycles = 1;
    waitResult(cycles);
    if (out_valid !== 1'b1) begin
      checkOutput("timeout", 64'(out_valid), 64'd1);
      return;
    end
    checkOutput("latency", 64'(cycles), 64'(latExp));
    checkOutput("w", 64'(w), 64'(wExp));
    checkOutput("fflags", 64'(fflags), 64'(fExp));
    checkOutput("inReadyBusy", 64'(in_ready), 64'd0);
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk); #1;
      checkOutput("holdValid", 64'(out_valid), 64'd1);
      checkOutput("holdW", 64'(w), 64'(wExp));
      checkOutput("holdFlags", 64'(fflags), 64'(fExp));
      checkOutput("holdInReady", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("validDrop", 64'(out_valid), 64'd0);
    checkOutput("inReadyRise", 64'(in_ready), 64'd1);
  endtask

  // Second operand held valid while the first is busy is taken only from IDLE
  task automatic backToBack(input logic [63:0] dA, input logic [63:0] dB);
    logic [31:0] wA, wB;
    logic [4:0]  fA, fB;
    int          latA, latB, cycles;
    refModel(dA, 1'b1, RNE, wA, fA, latA);
    refModel(dB, 1'b1, RNE, wB, fB, latB);
    d = dA; signed_ctrl = 1'b1; rm = RNE; in_valid = 1'b1;
    @(posedge clk); #1;
    d = dB;
    @(posedge clk); #1;
    checkOutput("b2bBusy", 64'(in_ready), 64'd0);
    cycles = 2;
    waitResult(cycles);
    checkOutput("b2bLatA", 64'(cycles), 64'(latA));
    checkOutput("b2bWA", 64'(w), 64'(wA));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("b2bIdle", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("b2bAcceptB", 64'(in_ready), 64'd0);
    cycles = 1;
    waitResult(cycles);
    checkOutput("b2bLatB", 64'(cycles), 64'(latB));
    checkOutput("b2bWB", 64'(w), 64'(wB));
    checkOutput("b2bFB", 64'(fflags), 64'(fB));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] rnd, op;
    logic [10:0] ex;
    int          sel;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; d = '0; signed_ctrl = 1'b0; rm = RNE;
    #1;
    checkOutput("rstOutValid", 64'(out_valid), 64'd0);
    checkOutput("rstInReady", 64'(in_ready), 64'd1);
    checkOutput("rstW", 64'(w), 64'd0);
    checkOutput("rstFlags", 64'(fflags), 64'd0);
    #21 rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(64'h4008_0000_0000_0000, 1'b1, RNE, 0);
    applyStimulus(64'h4004_0000_0000_0000, 1'b1, RNE, 0);
    applyStimulus(64'h4004_0000_0000_0000, 1'b1, RMM, 0);
    applyStimulus(64'h4004_0000_0000_0000, 1'b1, RUP, 0);
    applyStimulus(64'h4004_0000_0000_0000, 1'b1, RTZ, 0);
    applyStimulus(64'hBFF8_0000_0000_0000, 1'b1, RDN, 0);
    applyStimulus(64'hBFF8_0000_0000_0000, 1'b0, RTZ, 0);
    applyStimulus(64'hBFE0_0000_0000_0000, 1'b0, RTZ, 0);
    applyStimulus(64'h41E0_0000_0000_0000, 1'b1, RNE, 0);
    applyStimulus(64'h41E0_0000_0000_0000, 1'b0, RNE, 0);
    applyStimulus(64'hC1E0_0000_0000_0000, 1'b1, RNE, 0);
    applyStimulus(64'h7FF8_0000_0000_0000, 1'b1, RNE, 0);
    applyStimulus(64'hFFF0_0000_0000_0000, 1'b0, RNE, 0);
    applyStimulus(64'h8000_0000_0000_0000, 1'b1, RNE, 0);
    applyStimulus(64'h0000_0000_0000_0001, 1'b1, RUP, 0);
    applyStimulus(64'h4004_0000_0000_0000, 1'b1, RNE, 5);

    // Reset in the middle of the shift phase drops the operand
    d = 64'h4008_0000_0000_0000; signed_ctrl = 1'b1; rm = RNE; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("midRstValid", 64'(out_valid), 64'd0);
    checkOutput("midRstInReady", 64'(in_ready), 64'd1);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("postRstInReady", 64'(in_ready), 64'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checkOutput("abandoned", 64'(out_valid), 64'd0);
    end

    backToBack(64'h4004_0000_0000_0000, 64'hC00C_0000_0000_0000);

    for (int n = 0; n < 200; n++) begin
      rnd = {$urandom, $urandom};
      sel = int'($urandom_range(0, 19));
      if ($urandom_range(0, 3) == 0) rnd[39:0] = 40'd0;
      case (sel)
        0:       ex = 11'd0;
        1:       ex = 11'd0;
        2:       ex = 11'h7FF;
        3:       ex = 11'(1023 + 32 + int'($urandom_range(0, 8)));
        default: ex = 11'(1023 - 3 + int'($urandom_range(0, 35)));
      endcase
      op = {rnd[63], ex, rnd[51:0]};
      if (sel == 0) op[51:0] = 52'd0;
      applyStimulus(op, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
